// File: rtl/term_accumulator.sv
// term_accumulator: serially sums a run of FP terms from the term RAM through
// a shared external FP adder, answering the evaluator's start/done handshake.
module term_accumulator #(
  parameter int unsigned EXP_LEN      = 8,
  parameter int unsigned MANTISSA_LEN = 23,
  parameter int unsigned NUM_TERMS    = 32,
  localparam int unsigned W  = EXP_LEN + MANTISSA_LEN + 1,
  localparam int unsigned AW = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1,
  localparam int unsigned CW = $clog2(NUM_TERMS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          term_accumulation_start,
  input  logic [CW-1:0] term_count,
  output logic          term_accumulation_done,
  output logic          busy,
  output logic [W-1:0]  sum_out,
  output logic          term_rd_en,
  output logic [AW-1:0] term_addr,
  input  logic [W-1:0]  term_rd_data,
  output logic [W-1:0]  add_a,
  output logic [W-1:0]  add_b,
  output logic          add_start,
  input  logic          add_done,
  input  logic [W-1:0]  add_result
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_RD  = 3'd2,
    S_ADD_WAIT = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [CW-1:0] r_n;
  logic [AW-1:0] r_idx;
  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_add_a;
  logic [W-1:0]  r_add_b;
  logic          r_add_start;
  logic          r_done;
  logic          r_busy;
  logic [W-1:0]  r_sum;

  logic [CW-1:0] w_n_clamped;
  logic          w_last;

  // Requested count clamped to the term memory depth
  assign w_n_clamped = (term_count > CW'(NUM_TERMS)) ? CW'(NUM_TERMS) : term_count;

  // Current term is the final one of the run
  assign w_last = (CW'(r_idx) == (r_n - CW'(1)));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (term_accumulation_start) begin
          w_next_state = (w_n_clamped == CW'(0)) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH:    w_next_state = S_WAIT_RD;
      S_WAIT_RD:  w_next_state = S_ADD_WAIT;
      S_ADD_WAIT: begin
        if (add_done) begin
          w_next_state = w_last ? S_DONE : S_FETCH;
        end
      end
      S_DONE:     w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Datapath: run bookkeeping, adder operands, registered status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_n         <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_add_start <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_sum       <= '0;
    end else begin
      r_add_start <= 1'b0;
      r_done      <= (w_next_state == S_DONE);
      r_busy      <= (w_next_state != S_IDLE);

      unique case (r_state)
        S_IDLE: begin
          if (term_accumulation_start) begin
            r_n   <= w_n_clamped;
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        S_WAIT_RD: begin
          r_add_a     <= r_acc;
          r_add_b     <= term_rd_data;
          r_add_start <= 1'b1;
        end
        S_ADD_WAIT: begin
          if (add_done) begin
            r_acc <= add_result;
            if (!w_last) begin
              r_idx <= r_idx + AW'(1);
            end
          end
        end
        default: begin
        end
      endcase

      // Publish the final sum as DONE is entered; an empty run sums to +0.0
      if (w_next_state == S_DONE) begin
        r_sum <= (r_state == S_ADD_WAIT) ? add_result : '0;
      end
    end
  end

  // RAM read strobe and address follow the FETCH state directly
  assign term_rd_en             = (r_state == S_FETCH);
  assign term_addr              = r_idx;

  assign add_a                  = r_add_a;
  assign add_b                  = r_add_b;
  assign add_start              = r_add_start;
  assign term_accumulation_done = r_done;
  assign busy                   = r_busy;
  assign sum_out                = r_sum;

endmodule

// File: tb/tb_term_accumulator.sv
// tb_term_accumulator: drives runs against a term RAM model and a behavioural
// FP adder with programmable latency; expected results go through a scoreboard.
module tb_term_accumulator;

  localparam int unsigned NT = 32;

  logic        clk;
  logic        reset;
  logic        term_accumulation_start;
  logic [5:0]  term_count;
  logic        term_accumulation_done;
  logic        busy;
  logic [31:0] sum_out;
  logic        term_rd_en;
  logic [4:0]  term_addr;
  logic [31:0] term_rd_data = '0;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_start;
  logic        add_done = 1'b0;
  logic [31:0] add_result = '0;

  logic [31:0] mem [NT];
  int          lat = 1;
  bit          inj_done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] sum;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  term_accumulator dut (
    .clk                    (clk),
    .reset                  (reset),
    .term_accumulation_start(term_accumulation_start),
    .term_count             (term_count),
    .term_accumulation_done (term_accumulation_done),
    .busy                   (busy),
    .sum_out                (sum_out),
    .term_rd_en             (term_rd_en),
    .term_addr              (term_addr),
    .term_rd_data           (term_rd_data),
    .add_a                  (add_a),
    .add_b                  (add_b),
    .add_start              (add_start),
    .add_done               (add_done),
    .add_result             (add_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-precision <-> real helpers (normal numbers and zero only)
  function automatic real f2r(input logic [31:0] b);
    int  e;
    real v;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    v = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real x);
    logic s;
    int   e;
    real  v;
    if (x == 0.0) return 32'h0;
    s = (x < 0.0);
    v = s ? -x : x;
    e = 127;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    return {s, 8'(e), 23'($rtoi((v - 1.0) * 8388608.0))};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Term RAM: data valid the cycle after the read enable
  always @(posedge clk) begin
    if (term_rd_en) term_rd_data <= mem[term_addr];
  end

  // Behavioural adder: add_done lat cycles after the add_start-high cycle
  int          a_cnt = 0;
  logic [31:0] a_res = '0;
  always @(posedge clk) begin
    add_done <= 1'b0;
    if (add_start) begin
      a_cnt = lat;
      a_res = fp_add(add_a, add_b);
    end
    if (a_cnt > 0) begin
      a_cnt = a_cnt - 1;
      if (a_cnt == 0) begin
        add_done   <= 1'b1;
        add_result <= a_res;
      end
    end
    if (inj_done) add_done <= 1'b1;
  end

  // One run: start at cycle 0, observe every cycle until past the expected done
  task automatic do_run(input int cnt, input int latency, input bit noise,
                        input logic [31:0] exp_sum);
    int          n, exp_cyc, rel, reads, adds, dones;
    logic [31:0] acc_m;
    exp_t        e;
    n       = (cnt > int'(NT)) ? int'(NT) : cnt;
    exp_cyc = 1 + n * (3 + latency);
    lat     = latency;
    sb.push_back('{exp_sum, exp_cyc});
    acc_m = '0; reads = 0; adds = 0; dones = 0; rel = 0;
    term_count              = 6'(cnt);
    term_accumulation_start = 1'b1;
    while (rel < exp_cyc + 4) begin
      @(posedge clk); #1;
      rel++;
      if (term_rd_en) begin
        check_eq("rd_addr", 32'(term_addr), 32'(reads));
        check_eq("rd_cycle", 32'(rel), 32'(1 + reads * (3 + latency)));
        reads++;
      end
      if (add_start) begin
        if (adds < int'(NT)) begin
          check_eq("add_a", add_a, acc_m);
          check_eq("add_b", add_b, mem[adds]);
          acc_m = fp_add(acc_m, mem[adds]);
        end
        adds++;
      end
      if (term_accumulation_done) begin
        dones++;
        if (sb.size() == 0) begin
          check_eq("sb_pop", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check_eq("done_cycle", 32'(rel), 32'(e.cyc));
          check_eq("sum_out", sum_out, e.sum);
        end
      end
      term_accumulation_start = noise && (rel == 1 || rel == 3 || rel == exp_cyc);
      term_count              = noise ? 6'd7 : 6'(cnt);
      inj_done                = noise && (rel == 4);
    end
    term_accumulation_start = 1'b0;
    inj_done                = 1'b0;
    check_eq("done_count", 32'(dones), 32'd1);
    check_eq("read_count", 32'(reads), 32'(n));
    check_eq("add_count", 32'(adds), 32'(n));
    check_eq("busy_end", 32'(busy), 32'd0);
    check_eq("sb_left", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Main sequence
  initial begin
    int dones, busy_hi;
    reset                   = 1'b0;
    term_accumulation_start = 1'b0;
    term_count              = '0;
    for (int i = 0; i < int'(NT); i++) mem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(term_accumulation_done), 32'd0);
    check_eq("rst_add_start", 32'(add_start), 32'd0);
    check_eq("rst_rd_en", 32'(term_rd_en), 32'd0);
    check_eq("rst_addr", 32'(term_addr), 32'd0);
    check_eq("rst_add_a", add_a, 32'd0);
    check_eq("rst_add_b", add_b, 32'd0);
    check_eq("rst_sum", sum_out, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic run: 1+2+3+4
    mem[0] = 32'h3F800000; mem[1] = 32'h40000000;
    mem[2] = 32'h40400000; mem[3] = 32'h40800000;
    do_run(4, 1, 1'b0, 32'h41200000);

    // Empty run
    do_run(0, 1, 1'b0, 32'h00000000);

    // Long adder latency: 1.5 + -0.5
    mem[0] = 32'h3FC00000; mem[1] = 32'hBF000000;
    do_run(2, 5, 1'b0, 32'h3F800000);

    // Ignored starts and a spurious add_done on the basic run
    mem[0] = 32'h3F800000; mem[1] = 32'h40000000;
    mem[2] = 32'h40400000; mem[3] = 32'h40800000;
    do_run(4, 1, 1'b1, 32'h41200000);

    // Reset during ADD_WAIT of term 1, with a simultaneous start that must drop
    lat                     = 5;
    term_count              = 6'd4;
    term_accumulation_start = 1'b1;
    for (int rel = 1; rel <= 12; rel++) begin
      @(posedge clk); #1;
      term_accumulation_start = (rel == 12);
      term_count              = (rel == 12) ? 6'd1 : 6'd4;
      reset                   = (rel != 12);
    end
    @(posedge clk); #1;
    reset                   = 1'b1;
    term_accumulation_start = 1'b0;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_add_start", 32'(add_start), 32'd0);
    check_eq("mid_rst_sum", sum_out, 32'd0);
    check_eq("mid_rst_rd_en", 32'(term_rd_en), 32'd0);
    dones = 0; busy_hi = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (term_accumulation_done) dones++;
      if (busy || term_rd_en || add_start) busy_hi++;
    end
    check_eq("late_add_done_done", 32'(dones), 32'd0);
    check_eq("late_add_done_busy", 32'(busy_hi), 32'd0);
    mem[0] = 32'h40000000;
    do_run(1, 5, 1'b0, 32'h40000000);

    // Clamping: 40 requested, 32 summed (1+2+...+32 = 528)
    for (int i = 0; i < int'(NT); i++) mem[i] = r2f(real'(i + 1));
    do_run(40, 1, 1'b0, 32'h44040000);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
